// File: rtl/xadc_pad_scanner.sv
// XADC DRP sequencer: round-robin reads of four drum-pad aux channels with
// per-pad strike detection (threshold, peak capture, retrigger holdoff).
module xadc_pad_scanner #(
  parameter int unsigned SCAN_DIV     = 2500,
  parameter logic [11:0] THRESH       = 12'h200,
  parameter int unsigned PEAK_SCANS   = 8,
  parameter int unsigned HOLD_SCANS   = 200,
  parameter int unsigned DRDY_TIMEOUT = 64
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  input  logic [3:0]  pad_en,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  input  logic [15:0] do_in,
  input  logic        drdy,
  output logic        hit_valid,
  output logic [1:0]  hit_pad,
  output logic [11:0] hit_vel,
  output logic [11:0] last_sample,
  output logic        timeout_err
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_MAX = (HOLD_SCANS > PEAK_SCANS) ? HOLD_SCANS : PEAK_SCANS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TO_W    = $clog2(DRDY_TIMEOUT + 1);

  typedef enum logic [1:0] {S_WAIT_TICK, S_REQ, S_WAIT_DRDY, S_PROCESS} main_st_t;
  typedef enum logic [1:0] {P_IDLE, P_PEAK, P_HOLD} pad_st_t;

  main_st_t          state;
  logic [SCAN_W-1:0] scan_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [1:0]        ptr;
  logic [1:0]        sel_q;
  logic [11:0]       sample_q;
  pad_st_t           pad_st [4];
  logic [11:0]       peak_q [4];
  logic [CNT_W-1:0]  cnt_q  [4];

  logic              tc;
  logic              found;
  logic [1:0]        nxt_sel;
  pad_st_t           upd_st;
  logic [11:0]       upd_peak;
  logic [CNT_W-1:0]  upd_cnt;
  logic              upd_hit;
  logic              drp_unused;

  assign dwe        = 1'b0;
  assign tc         = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign drp_unused = ^do_in[3:0];

  function automatic logic [6:0] pad_addr(input logic [1:0] p);
    case (p)
      2'd0:    return 7'h12;
      2'd1:    return 7'h13;
      2'd2:    return 7'h1A;
      default: return 7'h1B;
    endcase
  endfunction

  // First enabled pad at or after the pointer, wrapping 3 -> 0.
  always_comb begin
    found   = 1'b0;
    nxt_sel = ptr;
    for (int i = 0; i < 4; i++) begin
      if (!found && pad_en[ptr + 2'(i)]) begin
        found   = 1'b1;
        nxt_sel = ptr + 2'(i);
      end
    end
  end

  // Strike update for the pad whose sample was just latched.
  always_comb begin
    upd_st   = pad_st[sel_q];
    upd_peak = peak_q[sel_q];
    upd_cnt  = cnt_q[sel_q];
    upd_hit  = 1'b0;
    case (pad_st[sel_q])
      P_IDLE: begin
        if (sample_q >= THRESH) begin
          upd_st   = P_PEAK;
          upd_peak = sample_q;
          upd_cnt  = CNT_W'(1);
        end
      end
      P_PEAK: begin
        if (sample_q > upd_peak) upd_peak = sample_q;
        upd_cnt = upd_cnt + CNT_W'(1);
      end
      P_HOLD: begin
        if (upd_cnt < CNT_W'(HOLD_SCANS)) upd_cnt = upd_cnt + CNT_W'(1);
        if (upd_cnt >= CNT_W'(HOLD_SCANS) && sample_q < THRESH) begin
          upd_st  = P_IDLE;
          upd_cnt = '0;
        end
      end
      default: upd_st = P_IDLE;
    endcase
    // Shared terminal check also covers a single-sample peak window.
    if (upd_st == P_PEAK && upd_cnt >= CNT_W'(PEAK_SCANS)) begin
      upd_hit = 1'b1;
      upd_st  = P_HOLD;
      upd_cnt = '0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      state       <= S_WAIT_TICK;
      scan_cnt    <= '0;
      to_cnt      <= '0;
      ptr         <= 2'd0;
      sel_q       <= 2'd0;
      sample_q    <= 12'h0;
      daddr       <= 7'h12;
      den         <= 1'b0;
      hit_valid   <= 1'b0;
      hit_pad     <= 2'd0;
      hit_vel     <= 12'h0;
      last_sample <= 12'h0;
      timeout_err <= 1'b0;
      for (int p = 0; p < 4; p++) begin
        pad_st[p] <= P_IDLE;
        peak_q[p] <= 12'h0;
        cnt_q[p]  <= '0;
      end
    end else begin
      den       <= 1'b0;
      hit_valid <= 1'b0;
      scan_cnt  <= tc ? '0 : scan_cnt + SCAN_W'(1);

      case (state)
        S_REQ: begin
          state  <= S_WAIT_DRDY;
          to_cnt <= '0;
        end
        S_WAIT_DRDY: begin
          if (drdy) begin
            sample_q <= do_in[15:4];
            state    <= S_PROCESS;
          end else if (to_cnt == TO_W'(DRDY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_WAIT_TICK;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_PROCESS: begin
          pad_st[sel_q] <= upd_st;
          peak_q[sel_q] <= upd_peak;
          cnt_q[sel_q]  <= upd_cnt;
          if (upd_hit) begin
            hit_valid <= 1'b1;
            hit_pad   <= sel_q;
            hit_vel   <= upd_peak;
          end
          if (upd_hit || sel_q == hit_pad) last_sample <= sample_q;
          state <= S_WAIT_TICK;
        end
        default: ;
      endcase

      // Terminal count overrides: keeps sample spacing exact and abandons a late read.
      if (tc) begin
        if (state == S_REQ || state == S_WAIT_DRDY) timeout_err <= 1'b1;
        for (int p = 0; p < 4; p++) begin
          if (!pad_en[p]) begin
            pad_st[p] <= P_IDLE;
            peak_q[p] <= 12'h0;
            cnt_q[p]  <= '0;
          end
        end
        if (found) begin
          sel_q <= nxt_sel;
          ptr   <= nxt_sel + 2'd1;
          daddr <= pad_addr(nxt_sel);
          den   <= 1'b1;
          state <= S_REQ;
        end else begin
          state <= S_WAIT_TICK;
        end
      end
    end
  end

endmodule

// File: tb/tb_xadc_pad_scanner.sv
// Bench for xadc_pad_scanner: XADC DRP responder fed from per-pad sample queues,
// with a hit scoreboard filled by each scenario and drained on hit_valid.
module tb_xadc_pad_scanner;

  localparam int unsigned SCAN_DIV     = 100;
  localparam logic [11:0] THRESH       = 12'h200;
  localparam int unsigned PEAK_SCANS   = 3;
  localparam int unsigned HOLD_SCANS   = 20;
  localparam int unsigned DRDY_TIMEOUT = 64;
  localparam int          LAT          = 4;
  localparam int          TAIL         = 12 * SCAN_DIV;

  typedef struct packed {
    logic [1:0]  pad;
    logic [11:0] vel;
    logic [11:0] last;
  } hit_t;

  typedef struct packed {
    logic [6:0] addr;
    int         cyc;
  } den_t;

  logic        CLK100MHZ = 1'b0;
  logic        reset_n   = 1'b0;
  logic [3:0]  pad_en    = 4'hF;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] do_in     = 16'h0;
  logic        drdy      = 1'b0;
  logic        hit_valid;
  logic [1:0]  hit_pad;
  logic [11:0] hit_vel;
  logic [11:0] last_sample;
  logic        timeout_err;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  hit_t        exp_q[$];
  den_t        den_log[$];
  logic [12:0] pq0[$], pq1[$], pq2[$], pq3[$];

  bit          pending       = 1'b0;
  int          wait_n        = 0;
  logic [11:0] resp_val      = 12'h0;
  bit          resp_wh       = 1'b0;
  int          last_drdy_cyc = -10;
  logic [11:0] last_drdy_val = 12'h0;
  int          wh_den_cyc    = -1;

  xadc_pad_scanner #(
    .SCAN_DIV(SCAN_DIV), .THRESH(THRESH), .PEAK_SCANS(PEAK_SCANS),
    .HOLD_SCANS(HOLD_SCANS), .DRDY_TIMEOUT(DRDY_TIMEOUT)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .reset_n(reset_n), .pad_en(pad_en),
    .daddr(daddr), .den(den), .dwe(dwe), .do_in(do_in), .drdy(drdy),
    .hit_valid(hit_valid), .hit_pad(hit_pad), .hit_vel(hit_vel),
    .last_sample(last_sample), .timeout_err(timeout_err)
  );

  initial forever #5 CLK100MHZ = ~CLK100MHZ;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  function automatic int pad_of(input logic [6:0] a);
    case (a)
      7'h12:   return 0;
      7'h13:   return 1;
      7'h1A:   return 2;
      7'h1B:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [12:0] pop_pad(input int p);
    logic [12:0] v;
    v = 13'h0;
    case (p)
      0: if (pq0.size() > 0) v = pq0.pop_front();
      1: if (pq1.size() > 0) v = pq1.pop_front();
      2: if (pq2.size() > 0) v = pq2.pop_front();
      3: if (pq3.size() > 0) v = pq3.pop_front();
      default: v = 13'h0;
    endcase
    return v;
  endfunction

  // XADC responder plus hit scoreboard, evaluated 1 time unit after each edge.
  always begin : xadc_model
    int          p;
    logic [12:0] v;
    hit_t        e;
    @(posedge CLK100MHZ);
    #1;
    drdy = 1'b0;
    if (pending) begin
      if (wait_n == 0) begin
        pending = 1'b0;
        if (!resp_wh) begin
          drdy          = 1'b1;
          do_in         = {resp_val, 4'($urandom)};
          last_drdy_cyc = cyc;
          last_drdy_val = resp_val;
        end
      end else begin
        wait_n = wait_n - 1;
      end
    end
    if (den === 1'b1) begin
      p = pad_of(daddr);
      tests_run++;
      if (p < 0 || dwe !== 1'b0) begin
        fails++;
        $display("FAIL drp_request: daddr=%h dwe=%b, required a pad address with dwe=0", daddr, dwe);
      end
      den_log.push_back('{daddr, cyc});
      v        = pop_pad(p);
      pending  = 1'b1;
      wait_n   = LAT - 1;
      resp_val = v[11:0];
      resp_wh  = v[12];
      if (v[12]) wh_den_cyc = cyc;
    end
    if (hit_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_hit: pad=%0d vel=%h at cycle %0d, no hit required", hit_pad, hit_vel, cyc);
      end else begin
        e = exp_q.pop_front();
        if (hit_pad !== e.pad || hit_vel !== e.vel || last_drdy_val !== e.last || cyc != last_drdy_cyc + 2) begin
          fails++;
          $display("FAIL hit_event: pad=%0d vel=%h final_sample=%h lag=%0d, required pad=%0d vel=%h final_sample=%h lag=2",
                   hit_pad, hit_vel, last_drdy_val, cyc - last_drdy_cyc, e.pad, e.vel, e.last);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic ticks(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wait_dens(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (den_log.size() < n && k < budget) begin
      ticks(1);
      k++;
    end
    ok = (den_log.size() >= n);
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    int k;
    k = 0;
    while ((pq0.size() + pq1.size() + pq2.size() + pq3.size() > 0 || pending) && k < budget) begin
      ticks(1);
      k++;
    end
    ok = (k < budget);
    ticks(TAIL);
  endtask

  task automatic push_n(input int p, input logic [12:0] v, input int n);
    repeat (n) begin
      case (p)
        0: pq0.push_back(v);
        1: pq1.push_back(v);
        2: pq2.push_back(v);
        default: pq3.push_back(v);
      endcase
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pad_en  = 4'hF;
    ticks(3);
    tests_run++;
    if ({daddr, den, dwe, hit_valid, hit_pad, hit_vel, last_sample, timeout_err} !==
        {7'h12, 1'b0, 1'b0, 1'b0, 2'd0, 12'h0, 12'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: daddr=%h den=%b dwe=%b hv=%b pad=%0d vel=%h last=%h to=%b, required 12/0/0/0/0/000/000/0",
               daddr, den, dwe, hit_valid, hit_pad, hit_vel, last_sample, timeout_err);
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] exp_a [5];
    int         rel;
    bit         ok;
    exp_a = '{7'h12, 7'h13, 7'h1A, 7'h1B, 7'h12};
    den_log.delete();
    rel     = cyc;
    reset_n = 1'b1;
    wait_dens(5, 6 * SCAN_DIV, ok);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL rr_den_count: got %0d requests, required 5", den_log.size());
    end else begin
      tests_run++;
      if (den_log[0].cyc - rel != SCAN_DIV) begin
        fails++;
        $display("FAIL rr_first_tick: first den %0d cycles after reset release, required %0d", den_log[0].cyc - rel, SCAN_DIV);
      end
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (den_log[i].addr !== exp_a[i]) begin
          fails++;
          $display("FAIL rr_addr[%0d]: got %h required %h", i, den_log[i].addr, exp_a[i]);
        end
        if (i > 0) begin
          tests_run++;
          if (den_log[i].cyc - den_log[i-1].cyc != SCAN_DIV) begin
            fails++;
            $display("FAIL rr_spacing[%0d]: got %0d cycles required %0d", i, den_log[i].cyc - den_log[i-1].cyc, SCAN_DIV);
          end
        end
      end
    end
    ticks(2);
  endtask

  task automatic test_pad_mask();
    bit ok;
    pad_en = 4'b0101;
    ticks(2);
    den_log.delete();
    wait_dens(5, 6 * SCAN_DIV, ok);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL mask_den_count: got %0d requests, required 5", den_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if ((den_log[i].addr !== 7'h12 && den_log[i].addr !== 7'h1A) ||
            (i > 0 && den_log[i].addr === den_log[i-1].addr)) begin
          fails++;
          $display("FAIL mask_addr[%0d]: got %h, required alternating 12/1A", i, den_log[i].addr);
        end
      end
    end
    ticks(2);
    pad_en = 4'b0000;
    ticks(2);
    den_log.delete();
    ticks(4 * SCAN_DIV);
    tests_run++;
    if (den_log.size() != 0) begin
      fails++;
      $display("FAIL mask_none: got %0d requests with pad_en=0, required 0", den_log.size());
    end
  endtask

  task automatic test_peak();
    bit ok;
    push_n(1, 13'h100, 1);
    push_n(1, 13'h300, 1);
    push_n(1, 13'h700, 1);
    push_n(1, 13'h500, 1);
    push_n(1, 13'h050, 1);
    exp_q.push_back('{2'd1, 12'h700, 12'h500});
    pad_en = 4'b0010;
    wait_drained(10 * SCAN_DIV, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL peak_hit_seen: drained=%b pending_hits=%0d, required 1 and 0", ok, exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if ({hit_pad, hit_vel, last_sample} !== {2'd1, 12'h700, 12'h000}) begin
      fails++;
      $display("FAIL peak_hold_outputs: pad=%0d vel=%h last=%h, required 1/700/000", hit_pad, hit_vel, last_sample);
    end
  endtask

  task automatic test_threshold();
    bit ok;
    push_n(0, 13'h1FF, 1);
    push_n(0, 13'h200, 1);
    push_n(0, 13'h1F0, 1);
    push_n(0, 13'h1E0, 1);
    push_n(0, 13'h0C0, 1);
    exp_q.push_back('{2'd0, 12'h200, 12'h1E0});
    pad_en = 4'b0001;
    wait_drained(10 * SCAN_DIV, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL thresh_hit_seen: drained=%b pending_hits=%0d, required 1 and 0", ok, exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if ({hit_pad, hit_vel, last_sample} !== {2'd0, 12'h200, 12'h000}) begin
      fails++;
      $display("FAIL thresh_outputs: pad=%0d vel=%h last=%h, required 0/200/000", hit_pad, hit_vel, last_sample);
    end
  endtask

  task automatic test_holdoff();
    bit ok;
    push_n(2, 13'h800, 30);
    push_n(2, 13'h000, 2);
    push_n(2, 13'h900, 3);
    push_n(2, 13'h000, 5);
    push_n(2, 13'h800, 25);
    push_n(2, 13'h000, 3);
    exp_q.push_back('{2'd2, 12'h800, 12'h800});
    exp_q.push_back('{2'd2, 12'h900, 12'h900});
    pad_en = 4'b0100;
    wait_drained(80 * SCAN_DIV, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL hold_hits_seen: drained=%b pending_hits=%0d, required 1 and 0", ok, exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if ({hit_pad, hit_vel} !== {2'd2, 12'h900}) begin
      fails++;
      $display("FAIL hold_last_hit: pad=%0d vel=%h, required 2/900", hit_pad, hit_vel);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    int k;
    wh_den_cyc = -1;
    push_n(3, 13'h400, 1);
    push_n(3, 13'h450, 1);
    push_n(3, 13'h1000, 1);
    push_n(3, 13'h300, 1);
    exp_q.push_back('{2'd3, 12'h450, 12'h300});
    pad_en = 4'b1001;
    k = 0;
    while (wh_den_cyc < 0 && k < 10 * SCAN_DIV) begin
      ticks(1);
      k++;
    end
    tests_run++;
    if (wh_den_cyc < 0) begin
      fails++;
      $display("FAIL to_request: withheld pad3 read never issued");
    end else begin
      t0 = wh_den_cyc;
      ticks(t0 + 60 - cyc);
      tests_run++;
      if (timeout_err !== 1'b0) begin
        fails++;
        $display("FAIL to_early: timeout_err=%b at den+60, required 0", timeout_err);
      end
      ticks(10);
      tests_run++;
      if (timeout_err !== 1'b1) begin
        fails++;
        $display("FAIL to_flag: timeout_err=%b at den+70, required 1", timeout_err);
      end
      k = 0;
      while (den_log[den_log.size()-1].cyc <= t0 && k < 2 * SCAN_DIV) begin
        ticks(1);
        k++;
      end
      tests_run++;
      if (den_log[den_log.size()-1].addr !== 7'h12 || den_log[den_log.size()-1].cyc - t0 != SCAN_DIV) begin
        fails++;
        $display("FAIL to_next_scan: addr=%h after %0d cycles, required 12 after %0d",
                 den_log[den_log.size()-1].addr, den_log[den_log.size()-1].cyc - t0, SCAN_DIV);
      end
    end
    wait_drained(20 * SCAN_DIV, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0 || hit_vel !== 12'h450 || hit_pad !== 2'd3) begin
      fails++;
      $display("FAIL to_state_kept: pending_hits=%0d pad=%0d vel=%h, required 0 and 3/450", exp_q.size(), hit_pad, hit_vel);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    int rel;
    pad_en = 4'hF;
    push_n(0, 13'h600, 3);
    k = 0;
    while (pq0.size() > 0 && k < 20 * SCAN_DIV) begin
      ticks(1);
      k++;
    end
    ticks(1);
    reset_n = 1'b0;
    ticks(1);
    tests_run++;
    if ({daddr, den, hit_valid, hit_pad, hit_vel, last_sample, timeout_err} !==
        {7'h12, 1'b0, 1'b0, 2'd0, 12'h0, 12'h0, 1'b0}) begin
      fails++;
      $display("FAIL midreset_values: daddr=%h den=%b hv=%b pad=%0d vel=%h last=%h to=%b, required 12/0/0/0/000/000/0",
               daddr, den, hit_valid, hit_pad, hit_vel, last_sample, timeout_err);
    end
    push_n(0, 13'h600, 1);
    exp_q.push_back('{2'd0, 12'h600, 12'h000});
    den_log.delete();
    rel     = cyc;
    reset_n = 1'b1;
    wait_dens(1, 2 * SCAN_DIV, ok);
    tests_run++;
    if (!ok || den_log[0].addr !== 7'h12 || den_log[0].cyc - rel != SCAN_DIV) begin
      fails++;
      $display("FAIL midreset_restart: got %0d requests, first addr=%h, required 7'h12 %0d cycles after release",
               den_log.size(), ok ? den_log[0].addr : 7'h0, SCAN_DIV);
    end
    wait_drained(20 * SCAN_DIV, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0 || {hit_pad, hit_vel, last_sample} !== {2'd0, 12'h600, 12'h000}) begin
      fails++;
      $display("FAIL midreset_fresh_strike: pending_hits=%0d pad=%0d vel=%h last=%h, required 0 and 0/600/000",
               exp_q.size(), hit_pad, hit_vel, last_sample);
      exp_q.delete();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_round_robin();
    test_pad_mask();
    test_peak();
    test_threshold();
    test_holdoff();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
